// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O slave with LED, cycle counter, TX byte FIFO and status registers.
//   clk, reset       : single clock, synchronous active-high reset
//   MemWrite         : processor write strobe
//   DataAdr          : byte address; [7:2] selects the register inside the I/O window
//   WriteData        : store data
//   ReadDataIO       : combinational read data, 0 outside the window
//   IOSel            : address falls inside the I/O window
//   LedOut           : LED register
//   TxValid, TxData  : TX FIFO head, drained by TxReady
//   TxReady          : consumer accepts the head byte
// Optional macro MMIO_CYCLE_COUNTER_EN includes the free-running CYCLE counter.
module mmio_responder #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] IO_BASE = 32'hFFFF_FF00,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] DataAdr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadDataIO,
    output logic             IOSel,
    output logic [7:0]       LedOut,
    output logic             TxValid,
    output logic [7:0]       TxData,
    input  logic             TxReady
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]       led;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic [5:0]       sel;
    logic             we, wr_tx, full, empty, pop, push, ovf_set, ovf_clr;
    logic [WIDTH-1:0] cycle, status;
    logic             unused_bits;

    assign sel     = DataAdr[7:2];
    assign IOSel   = DataAdr[WIDTH-1:8] == IO_BASE[WIDTH-1:8];
    assign we      = MemWrite & IOSel;
    assign wr_tx   = we && sel == 6'd2;
    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign TxValid = !empty;
    assign TxData  = empty ? 8'h00 : mem[rd_ptr];
    assign pop     = TxValid & TxReady;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push    = wr_tx & (!full | pop);
    assign ovf_set = wr_tx & full & !pop;
    assign ovf_clr = we && sel == 6'd3 && WriteData[2];
    assign LedOut  = led;
    assign unused_bits = ^{DataAdr[1:0], WriteData[WIDTH-1:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            led    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (we && sel == 6'd0)
                led <= WriteData[7:0];
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            ovf   <= ovf_set | (ovf & !ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= WriteData[7:0];
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset || (we && sel == 6'd1))
            cycle <= '0;
        else
            cycle <= cycle + 1'b1;
    end
`else
    assign cycle = '0;
`endif

    always_comb begin
        status          = '0;
        status[0]       = empty;
        status[1]       = full;
        status[2]       = ovf;
        status[4 +: CW] = count;
    end

    assign ReadDataIO = !IOSel       ? '0 :
                        sel == 6'd0  ? WIDTH'(led) :
                        sel == 6'd1  ? cycle :
                        sel == 6'd3  ? status : '0;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: table-driven register checks plus a TX scoreboard for mmio_responder.
module tb_mmio_responder;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int DEPTH = 4;
`ifdef MMIO_CYCLE_COUNTER_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk, reset, MemWrite, TxReady, IOSel, TxValid;
    logic [31:0] DataAdr, WriteData, ReadDataIO;
    logic [7:0]  LedOut, TxData;
    logic [11:0] rd2;
    logic        iosel2, txv2;
    logic [7:0]  led2, txd2;
    logic [7:0]  q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        iosel;
        logic [7:0]  led;
    } vec_t;
    vec_t tbl [17];

    mmio_responder dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadDataIO(ReadDataIO), .IOSel(IOSel),
        .LedOut(LedOut), .TxValid(TxValid), .TxData(TxData), .TxReady(TxReady)
    );

    // Narrow instance so the counter wrap is reachable in a few thousand cycles.
    mmio_responder #(.WIDTH(12), .IO_BASE(12'hF00), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .MemWrite(1'b0), .DataAdr(12'hF04),
        .WriteData(12'h000), .ReadDataIO(rd2), .IOSel(iosel2),
        .LedOut(led2), .TxValid(txv2), .TxData(txd2), .TxReady(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every handshake must deliver the oldest accepted byte.
    always @(negedge clk) begin
        if (!reset && TxValid && TxReady) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_pop: got %h expected no pop (scoreboard empty)", TxData);
            end else
                chk("tx_order", {24'h0, TxData}, {24'h0, q.pop_front()});
        end
    end

    task automatic rst();
        reset = 1'b1;
        TxReady = 1'b0;
        MemWrite = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1;
        chk(nm, ReadDataIO, exp);
    endtask

    // Bus write; a TX push is queued when the model says there is room after this cycle's pop.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        @(negedge clk);
        #1;
        if ((a & 32'hFFFF_FFFC) == BASE + 32'h8 && q.size() < DEPTH)
            q.push_back(d[7:0]);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic drain();
        TxReady = 1'b1;
        for (int i = 0; i < 12 && TxValid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_txvalid", {31'h0, TxValid}, 32'h0);
        chk("drain_queue", q.size(), 32'h0);
        TxReady = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        MemWrite = 1'b0;
        DataAdr = '0;
        WriteData = '0;
        TxReady = 1'b0;
        tbl[0]  = '{1'b0, BASE,            32'h0,          32'h0,  1'b1, 8'h00};
        tbl[1]  = '{1'b0, BASE + 32'hC,    32'h0,          32'h1,  1'b1, 8'h00};
        tbl[2]  = '{1'b1, BASE,            32'hA5,         32'h0,  1'b1, 8'h00};
        tbl[3]  = '{1'b0, BASE,            32'h0,          32'hA5, 1'b1, 8'hA5};
        tbl[4]  = '{1'b0, BASE + 32'h1,    32'h0,          32'hA5, 1'b1, 8'hA5};
        tbl[5]  = '{1'b0, 32'h1000_0000,   32'h0,          32'h0,  1'b0, 8'hA5};
        tbl[6]  = '{1'b1, 32'h0000_0000,   32'hFF,         32'h0,  1'b0, 8'hA5};
        tbl[7]  = '{1'b0, BASE,            32'h0,          32'hA5, 1'b1, 8'hA5};
        tbl[8]  = '{1'b1, BASE + 32'h3,    32'h1234_5678,  32'hA5, 1'b1, 8'hA5};
        tbl[9]  = '{1'b0, BASE,            32'h0,          32'h78, 1'b1, 8'h78};
        tbl[10] = '{1'b0, BASE + 32'h8,    32'h0,          32'h0,  1'b1, 8'h78};
        tbl[11] = '{1'b0, BASE + 32'h10,   32'h0,          32'h0,  1'b1, 8'h78};
        tbl[12] = '{1'b1, BASE + 32'h20,   32'hFF,         32'h0,  1'b1, 8'h78};
        tbl[13] = '{1'b0, BASE + 32'hFC,   32'h0,          32'h0,  1'b1, 8'h78};
        tbl[14] = '{1'b1, BASE + 32'hC,    32'hFFFF_FFFF,  32'h1,  1'b1, 8'h78};
        tbl[15] = '{1'b0, BASE + 32'hC,    32'h0,          32'h1,  1'b1, 8'h78};
        tbl[16] = '{1'b0, 32'hFFFF_FE00,   32'h0,          32'h0,  1'b0, 8'h78};

        rst();
        rd("reset_cycle", BASE + 32'h4, 32'h0);
        rd("reset_led_reg", BASE, 32'h0);
        rd("reset_status", BASE + 32'hC, 32'h1);
        chk("reset_ledout", {24'h0, LedOut}, 32'h0);
        chk("reset_txvalid", {31'h0, TxValid}, 32'h0);
        chk("reset_txdata", {24'h0, TxData}, 32'h0);

        repeat (10) @(posedge clk);
        #1;
        rd("cycle_10", BASE + 32'h4, CYC_EN ? 32'd10 : 32'd0);
        repeat (4085) @(posedge clk);
        #1;
        chk("cycle_allones", {20'h0, rd2}, CYC_EN ? 32'hFFF : 32'h0);
        @(posedge clk);
        #1;
        chk("cycle_wrap", {20'h0, rd2}, 32'h0);
        wr(BASE + 32'h4, 32'h1234);
        rd("cycle_cleared", BASE + 32'h4, 32'h0);
        @(posedge clk);
        #1;
        rd("cycle_after_clear", BASE + 32'h4, CYC_EN ? 32'd1 : 32'd0);

        for (int i = 0; i < 17; i++) begin
            MemWrite = tbl[i].mw;
            DataAdr = tbl[i].adr;
            WriteData = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), ReadDataIO, tbl[i].rd);
            chk($sformatf("vec%0d_iosel", i), {31'h0, IOSel}, {31'h0, tbl[i].iosel});
            chk($sformatf("vec%0d_led", i), {24'h0, LedOut}, {24'h0, tbl[i].led});
            @(posedge clk);
            #1;
            MemWrite = 1'b0;
        end

        rst();
        wr(BASE + 32'h8, 32'h11);
        wr(BASE + 32'h8, 32'h22);
        wr(BASE + 32'h8, 32'h33);
        wr(BASE + 32'h8, 32'h44);
        rd("full_status", BASE + 32'hC, 32'h42);
        rd("txdata_reads_zero", BASE + 32'h8, 32'h0);
        wr(BASE + 32'h8, 32'h55);
        rd("ovf_status", BASE + 32'hC, 32'h46);
        chk("hold_txdata", {24'h0, TxData}, 32'h11);
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_txdata%0d", i), {24'h0, TxData}, 32'h11 * (i + 1));
            @(posedge clk);
            #1;
        end
        chk("seq_empty", {31'h0, TxValid}, 32'h0);
        TxReady = 1'b0;

        wr(BASE + 32'hC, 32'h4);
        rd("ovf_cleared", BASE + 32'hC, 32'h1);
        wr(BASE + 32'h8, 32'hA1);
        wr(BASE + 32'h8, 32'hA2);
        wr(BASE + 32'h8, 32'hA3);
        wr(BASE + 32'h8, 32'hA4);
        TxReady = 1'b1;
        wr(BASE + 32'h8, 32'h66);
        rd("full_pushpop_status", BASE + 32'hC, 32'h42);
        drain();

        wr(BASE + 32'h8, 32'hB1);
        wr(BASE + 32'h8, 32'hB2);
        wr(BASE + 32'h8, 32'hB3);
        wr(BASE + 32'h8, 32'hB4);
        wr(BASE + 32'h8, 32'hB5);
        rd("ovf_again", BASE + 32'hC, 32'h46);
        wr(BASE + 32'hC, 32'hFFFF_FFFB);
        rd("ovf_kept_bit2_zero", BASE + 32'hC, 32'h46);
        wr(BASE + 32'hC, 32'h4);
        rd("ovf_clear_full", BASE + 32'hC, 32'h42);
        drain();

        TxReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr(BASE + 32'h8, 32'hC0 + i);
            rd($sformatf("stream_status%0d", i), BASE + 32'hC, 32'h10);
            chk($sformatf("stream_valid%0d", i), {31'h0, TxValid}, 32'h1);
        end
        @(posedge clk);
        #1;
        rd("stream_done", BASE + 32'hC, 32'h1);
        chk("stream_queue", q.size(), 32'h0);
        TxReady = 1'b0;

        wr(BASE, 32'h3C);
        wr(BASE + 32'h8, 32'hD1);
        wr(BASE + 32'h8, 32'hD2);
        wr(BASE + 32'h8, 32'hD3);
        rd("pre_reset_status", BASE + 32'hC, 32'h30);
        chk("pre_reset_led", {24'h0, LedOut}, 32'h3C);
        reset = 1'b1;
        TxReady = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        TxReady = 1'b0;
        chk("midreset_txvalid", {31'h0, TxValid}, 32'h0);
        chk("midreset_txdata", {24'h0, TxData}, 32'h0);
        chk("midreset_led", {24'h0, LedOut}, 32'h0);
        rd("midreset_status", BASE + 32'hC, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
